// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan controller: several digit positions share one
//   seven-segment decoder. Codes are double-buffered (shadow written by
//   load, active copied from shadow only at frame start), and each digit
//   is shown for SCAN_DIV cycles.
//
//   Optional feature macro: SCAN_BLANK_EN
//     defined   - a BLANK guard of BLANK_CYC all-off cycles precedes every
//                 digit (anti-ghosting).
//     undefined - digits switch directly SHOW -> SHOW; BLANK_CYC is ignored.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         scan enable; low returns to IDLE with all digits off
//   load       one-cycle strobe capturing codes_in/valid_in into shadow
//   codes_in   DIGITS*CODE_W digit codes, digit 0 in the LSBs
//   valid_in   per-digit lit mask
//   code       code to the shared decoder
//   dec_en     decoder enable
//   an_n       active-low digit selects, at most one low
//   frame_done one-cycle pulse with the first cycle of a new frame
//   busy       high whenever the scanner is not IDLE
`timescale 1ns/1ps

module display_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int CODE_W    = 3,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     load,
    input  logic [DIGITS*CODE_W-1:0] codes_in,
    input  logic [DIGITS-1:0]        valid_in,
    output logic [CODE_W-1:0]        code,
    output logic                     dec_en,
    output logic [DIGITS-1:0]        an_n,
    output logic                     frame_done,
    output logic                     busy
);

    if (DIGITS < 2 || DIGITS > 8 || CODE_W < 1 || SCAN_DIV < 1 || BLANK_CYC < 1) begin : g_param_check
        $error("display_scan_ctrl: illegal parameter value");
    end

    localparam int IDX_W = $clog2(DIGITS);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

`ifdef SCAN_BLANK_EN
    localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYC - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} state_t;
    logic [BLK_W-1:0] blk_cnt;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd2} state_t;
`endif

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [DIV_W-1:0]          div_cnt;
    logic [DIGITS*CODE_W-1:0]  shadow_codes, active_codes;
    logic [DIGITS-1:0]         shadow_mask,  active_mask;
    logic                      pending;

    // Bank/index that become current after the present SHOW slot ends.
    logic                      last_digit;
    logic [IDX_W-1:0]          nxt_idx;
    logic [DIGITS*CODE_W-1:0]  nxt_codes;
    logic [DIGITS-1:0]         nxt_mask;

    function automatic logic [CODE_W-1:0] code_at(input logic [DIGITS*CODE_W-1:0] bank,
                                                  input logic [IDX_W-1:0] i);
        return bank[int'(i)*CODE_W +: CODE_W];
    endfunction

    function automatic logic [DIGITS-1:0] sel_at(input logic [DIGITS-1:0] mask,
                                                 input logic [IDX_W-1:0] i);
        logic [DIGITS-1:0] s;
        s    = '1;
        s[i] = ~mask[i];
        return s;
    endfunction

    always_comb begin
        last_digit = (idx == IDX_LAST);
        nxt_idx    = last_digit ? '0 : idx + 1'b1;
        nxt_codes  = active_codes;
        nxt_mask   = active_mask;
        if (last_digit && pending) begin
            nxt_codes = shadow_codes;
            nxt_mask  = shadow_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            div_cnt      <= '0;
`ifdef SCAN_BLANK_EN
            blk_cnt      <= '0;
`endif
            shadow_codes <= '0;
            shadow_mask  <= '0;
            active_codes <= '0;
            active_mask  <= '0;
            pending      <= 1'b0;
            code         <= '0;
            dec_en       <= 1'b0;
            an_n         <= '1;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // A load in the same cycle as a bank swap keeps pending set, so
            // the swap uses the old shadow and the new data waits a frame.
            if (load) begin
                shadow_codes <= codes_in;
                shadow_mask  <= valid_in;
                pending      <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        active_codes <= shadow_codes;
                        active_mask  <= shadow_mask;
                        if (!load) pending <= 1'b0;
                        idx     <= '0;
                        div_cnt <= '0;
                        busy    <= 1'b1;
                        code    <= code_at(shadow_codes, '0);
`ifdef SCAN_BLANK_EN
                        state   <= BLANK;
                        blk_cnt <= '0;
                        dec_en  <= 1'b0;
                        an_n    <= '1;
`else
                        state   <= SHOW;
                        dec_en  <= shadow_mask[0];
                        an_n    <= sel_at(shadow_mask, '0);
`endif
                    end
                end

                default: begin
                    if (!en) begin
                        state   <= IDLE;
                        idx     <= '0;
                        div_cnt <= '0;
`ifdef SCAN_BLANK_EN
                        blk_cnt <= '0;
`endif
                        code    <= '0;
                        dec_en  <= 1'b0;
                        an_n    <= '1;
                        busy    <= 1'b0;
                    end
`ifdef SCAN_BLANK_EN
                    else if (state == BLANK) begin
                        if (blk_cnt == BLK_LAST) begin
                            blk_cnt <= '0;
                            state   <= SHOW;
                            dec_en  <= active_mask[idx];
                            an_n    <= sel_at(active_mask, idx);
                        end else begin
                            blk_cnt <= blk_cnt + 1'b1;
                        end
                    end
`endif
                    else begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt      <= '0;
                            idx          <= nxt_idx;
                            active_codes <= nxt_codes;
                            active_mask  <= nxt_mask;
                            code         <= code_at(nxt_codes, nxt_idx);
                            if (last_digit) begin
                                frame_done <= 1'b1;
                                if (!load) pending <= 1'b0;
                            end
`ifdef SCAN_BLANK_EN
                            state   <= BLANK;
                            blk_cnt <= '0;
                            dec_en  <= 1'b0;
                            an_n    <= '1;
`else
                            state   <= SHOW;
                            dec_en  <= nxt_mask[nxt_idx];
                            an_n    <= sel_at(nxt_mask, nxt_idx);
`endif
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl (DIGITS=4, CODE_W=3, SCAN_DIV=8,
// BLANK_CYC=2). Expected per-cycle outputs are generated from a slot-based
// frame model into a queue and popped one entry per clock.
`timescale 1ns/1ps

module tb_display_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int CODE_W = 3;
    localparam int DIV    = 8;
`ifdef SCAN_BLANK_EN
    localparam int BLK = 2;
`else
    localparam int BLK = 0;
`endif
    localparam int SLOT = BLK + DIV;
    localparam int F    = DIGITS * SLOT;

    typedef struct packed {
        logic [3:0] an_n;
        logic       dec_en;
        logic [2:0] code;
        logic       fd;
        logic       busy;
    } exp_t;

    localparam exp_t IDLE_V = '{an_n: 4'hF, dec_en: 1'b0, code: 3'd0, fd: 1'b0, busy: 1'b0};

    logic        clk = 1'b0;
    logic        rst_n, en, load;
    logic [11:0] codes_in;
    logic [3:0]  valid_in;
    logic [2:0]  code;
    logic        dec_en;
    logic [3:0]  an_n;
    logic        frame_done, busy;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    localparam logic [11:0] A      = {3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [11:0] SEVENS = {3'd7, 3'd7, 3'd7, 3'd7};
    localparam logic [11:0] B      = {3'd1, 3'd0, 3'd3, 3'd2};
    localparam logic [11:0] C      = {3'd4, 3'd5, 3'd6, 3'd1};

    display_scan_ctrl #(
        .DIGITS   (DIGITS),
        .CODE_W   (CODE_W),
        .SCAN_DIV (DIV),
        .BLANK_CYC(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .codes_in  (codes_in),
        .valid_in  (valid_in),
        .code      (code),
        .dec_en    (dec_en),
        .an_n      (an_n),
        .frame_done(frame_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs();
        exp_t o;
        o.an_n   = an_n;
        o.dec_en = dec_en;
        o.code   = code;
        o.fd     = frame_done;
        o.busy   = busy;
        return o;
    endfunction

    task automatic check_vec(input string tag, input exp_t o, input exp_t e);
        checks++;
        assert (o === e) passes++;
        else $error("FAIL %s @%0t: got an_n=%b dec_en=%b code=%0d frame_done=%b busy=%b, expected an_n=%b dec_en=%b code=%0d frame_done=%b busy=%b",
                    tag, $time, o.an_n, o.dec_en, o.code, o.fd, o.busy,
                    e.an_n, e.dec_en, e.code, e.fd, e.busy);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back(IDLE_V);
    endtask

    // One full frame: each digit gets BLK all-off cycles then DIV lit cycles.
    task automatic push_frame(input logic [11:0] codes, input logic [3:0] mask, input logic fd);
        exp_t e;
        for (int d = 0; d < DIGITS; d++) begin
            for (int c = 0; c < SLOT; c++) begin
                e.an_n   = 4'hF;
                e.dec_en = 1'b0;
                e.code   = codes[d*3 +: 3];
                e.fd     = fd && (d == 0) && (c == 0);
                e.busy   = 1'b1;
                if (c >= BLK) begin
                    e.dec_en = mask[d];
                    if (mask[d]) e.an_n[d] = 1'b0;
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        assert (q.size() > 0) passes++;
        else $error("FAIL %s: scoreboard depth got %0d, expected >0", tag, q.size());
        if (q.size() > 0) begin
            e = q.pop_front();
            check_vec(tag, obs(), e);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        codes_in = '0;
        valid_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset", obs(), IDLE_V);
        rst_n = 1'b1;
        push_idle(2);
        run(2, "idle");

        // Load while idle; nothing visible until scanning starts.
        codes_in = A;
        valid_in = 4'b1111;
        load     = 1'b1;
        push_idle(1);
        run(1, "load_idle");
        load = 1'b0;

        en = 1'b1;
        push_frame(A, 4'b1111, 1'b0);
        run(F, "frame0");

        // Mask 0101 loaded mid-frame: visible from the next frame.
        push_frame(A, 4'b1111, 1'b1);
        run(5, "frame1");
        valid_in = 4'b0101;
        load     = 1'b1;
        run(1, "frame1");
        load = 1'b0;
        run(F - 6, "frame1");

        push_frame(A, 4'b0101, 1'b1);
        run(15, "frame2_mask");
        codes_in = SEVENS;
        valid_in = 4'b1111;
        load     = 1'b1;
        run(1, "frame2_mask");
        load = 1'b0;
        run(F - 16, "frame2_mask");

        push_frame(SEVENS, 4'b1111, 1'b1);
        run(7, "frame3_sevens");
        codes_in = B;
        load     = 1'b1;
        run(1, "frame3_sevens");
        load = 1'b0;
        run(F - 8, "frame3_sevens");

        // Load on the boundary edge: this frame takes B, C waits a frame.
        codes_in = C;
        valid_in = 4'b1011;
        load     = 1'b1;
        push_frame(B, 4'b1111, 1'b1);
        run(1, "frame4_boundary");
        load = 1'b0;
        run(F - 1, "frame4_boundary");

        // Drop en during digit 2 SHOW.
        push_frame(C, 4'b1011, 1'b1);
        run(2*SLOT + BLK + 3, "frame5");
        en = 1'b0;
        q.delete();
        push_idle(3);
        run(3, "en_off");

        en = 1'b1;
        push_frame(C, 4'b1011, 1'b0);
        run(F, "restart");

        // Asynchronous reset in digit 1 SHOW, between clock edges.
        push_frame(C, 4'b1011, 1'b1);
        run(SLOT + BLK + 2, "pre_reset");
        #3 rst_n = 1'b0;
        #1 check_vec("async_reset", obs(), IDLE_V);
        en = 1'b0;
        q.delete();
        push_idle(1);
        run(1, "reset_hold");
        rst_n = 1'b1;
        push_idle(2);
        run(2, "post_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
